// File: rtl/sys_defs.sv
// Shared processor definitions: superscalar width, dispatch buffer depth and the
// decoded-instruction packet that flows from decode into dispatch.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef N_DB
`define N_DB 16
`endif

package sys_defs;

    localparam int N_WAY_DEFAULT = `N_WAY;
    localparam int N_DB_DEFAULT  = `N_DB;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_reg;
        logic        halt;
    } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/lead_ones_count.sv
// Counts the run of consecutive ones starting at bit 0; bits after the first zero
// are ignored.
module lead_ones_count #(
    parameter  int W  = 2,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] ones
);

    logic run;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it
        // unassigned and no latch is inferred; blocking '=' is right inside always_comb.
        ones = '0;
        run  = 1'b1;
        for (int i = 0; i < W; i++) begin
            run = run & bits[i];
            if (run) begin
                ones = CW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order dispatch buffer: a circular queue between decode and rename that accepts
// and releases up to N_WAY instructions per cycle, oldest in lane 0.
module dispatch_buffer
    import sys_defs::*;
#(
    parameter  int N_WAY = N_WAY_DEFAULT,
    parameter  int DEPTH = N_DB_DEFAULT,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int NW    = $clog2(N_WAY + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [N_WAY-1:0]    in_valid,
    input  DISPATCH_PACKET_R10K in_packet [N_WAY],
    output logic                in_ready,
    input  logic [N_WAY-1:0]    dispatched,
    output DISPATCH_PACKET_R10K dispatch_packet [N_WAY],
    output logic [CW-1:0]       count
);

    DISPATCH_PACKET_R10K entries [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    rd_idx [N_WAY];
    logic [PW-1:0]    wr_idx [N_WAY];
    logic [N_WAY-1:0] out_valid;
    logic [NW-1:0]    enq_raw;
    logic [NW-1:0]    enq_n;
    logic [NW-1:0]    deq_n;

    // Outputs depend only on head/count and the storage, never on this cycle's inputs.
    always_comb begin
        in_ready = (CW'(DEPTH) - count) >= CW'(N_WAY);
        for (int i = 0; i < N_WAY; i++) begin
            rd_idx[i]          = head + PW'(i);
            wr_idx[i]          = tail + PW'(i);
            out_valid[i]       = CW'(i) < count;
            dispatch_packet[i] = entries[rd_idx[i]];
            dispatch_packet[i].valid = out_valid[i];
        end
    end

    lead_ones_count #(.W(N_WAY)) u_enq_count (
        .bits (in_valid),
        .ones (enq_raw)
    );

    lead_ones_count #(.W(N_WAY)) u_deq_count (
        .bits (dispatched & out_valid),
        .ones (deq_n)
    );

    assign enq_n = in_ready ? enq_raw : '0;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(enq_n);
            head  <= head + PW'(deq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    // NOTE: payload storage is deliberately not reset; whether an entry is live is
    // decided solely by head/count, which are.
    always_ff @(posedge clock) begin
        if (!flush) begin
            for (int i = 0; i < N_WAY; i++) begin
                if (NW'(i) < enq_n) begin
                    entries[wr_idx[i]] <= in_packet[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer (N_WAY=2, DEPTH=8) against a queue model.
module tb_dispatch_buffer;
    import sys_defs::*;

    localparam int N_WAY = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                clock = 1'b0;
    logic                reset;
    logic                flush;
    logic [N_WAY-1:0]    in_valid;
    DISPATCH_PACKET_R10K in_packet [N_WAY];
    logic                in_ready;
    logic [N_WAY-1:0]    dispatched;
    DISPATCH_PACKET_R10K dispatch_packet [N_WAY];
    logic [CW-1:0]       count;

    int n_compared   = 0;
    int n_mismatched = 0;

    DISPATCH_PACKET_R10K model_q [$];
    DISPATCH_PACKET_R10K sent [$];
    DISPATCH_PACKET_R10K got [$];

    always #5 clock = ~clock;

    dispatch_buffer #(.N_WAY(N_WAY), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_packet       (in_packet),
        .in_ready        (in_ready),
        .dispatched      (dispatched),
        .dispatch_packet (dispatch_packet),
        .count           (count)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Number of consecutive set lanes from lane 0, looking at no more than limit lanes.
    function automatic int lead1(input logic [N_WAY-1:0] b, input int limit);
        int n = 0;
        for (int i = 0; i < N_WAY && i < limit; i++) begin
            if (!b[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic DISPATCH_PACKET_R10K rand_packet(input logic v);
        DISPATCH_PACKET_R10K p;
        p.valid    = v;
        p.pc       = $urandom;
        p.inst     = $urandom;
        p.dest_reg = 5'($urandom);
        p.halt     = 1'($urandom);
        return p;
    endfunction

    task automatic check_outputs(input string tag);
        int n;
        n = model_q.size();
        check({tag, "/count"}, 96'(count), 96'(n));
        check({tag, "/in_ready"}, 96'(in_ready), 96'(DEPTH - n >= N_WAY));
        for (int i = 0; i < N_WAY; i++) begin
            check($sformatf("%s/valid%0d", tag, i), 96'(dispatch_packet[i].valid), 96'(i < n));
            if (i < n) begin
                check($sformatf("%s/lane%0d", tag, i), 96'(dispatch_packet[i]), 96'(model_q[i]));
            end
        end
    endtask

    // One clock cycle: drive inputs, check state-only outputs, apply the edge, update the model.
    task automatic cycle(input logic [N_WAY-1:0] iv, input logic [N_WAY-1:0] dsp,
                         input logic fl, input string tag);
        int n;
        int enq;
        int deq;
        DISPATCH_PACKET_R10K p;
        DISPATCH_PACKET_R10K snap [N_WAY];
        for (int i = 0; i < N_WAY; i++) begin
            in_packet[i] = rand_packet(iv[i]);
        end
        in_valid   = iv;
        dispatched = dsp;
        flush      = fl;
        #1;
        check_outputs(tag);
        for (int i = 0; i < N_WAY; i++) begin
            snap[i] = dispatch_packet[i];
        end
        n = model_q.size();
        @(posedge clock);
        if (fl) begin
            model_q.delete();
        end else begin
            deq = lead1(dsp, n);
            enq = (DEPTH - n >= N_WAY) ? lead1(iv, N_WAY) : 0;
            for (int k = 0; k < deq; k++) begin
                got.push_back(snap[k]);
                void'(model_q.pop_front());
            end
            for (int k = 0; k < enq; k++) begin
                p       = in_packet[k];
                p.valid = 1'b1;
                model_q.push_back(p);
                sent.push_back(p);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = '0;
        dispatched = '0;
        for (int i = 0; i < N_WAY; i++) begin
            in_packet[i] = '0;
        end
        #12;
        check("reset/count", 96'(count), 96'(0));
        check("reset/in_ready", 96'(in_ready), 96'(1));
        check("reset/valid", 96'({dispatch_packet[1].valid, dispatch_packet[0].valid}), 96'(0));
        @(negedge clock);
        reset = 1'b1;
        check_outputs("after_reset");

        // Two instructions in, nothing taken.
        cycle(2'b11, 2'b00, 1'b0, "enq_ab");
        check("ab/count", 96'(count), 96'(2));
        check("ab/lane0", 96'(dispatch_packet[0]), 96'(sent[0]));
        check("ab/lane1", 96'(dispatch_packet[1]), 96'(sent[1]));

        // Take A while C,D arrive: head becomes B, then C.
        cycle(2'b11, 2'b01, 1'b0, "deq_a_enq_cd");
        check("bcd/count", 96'(count), 96'(3));
        check("bcd/lane0", 96'(dispatch_packet[0]), 96'(sent[1]));
        check("bcd/lane1", 96'(dispatch_packet[1]), 96'(sent[2]));

        // Acceptance on lane 1 only is non-contiguous: nothing leaves.
        cycle(2'b00, 2'b10, 1'b0, "deq_gap");
        check("gap/count", 96'(count), 96'(3));
        check("gap/lane0", 96'(dispatch_packet[0]), 96'(sent[1]));

        // Fill to 7: in_ready drops and a further pair is rejected.
        cycle(2'b11, 2'b00, 1'b0, "fill5");
        cycle(2'b11, 2'b00, 1'b0, "fill7");
        check("c7/count", 96'(count), 96'(7));
        check("c7/in_ready", 96'(in_ready), 96'(0));
        cycle(2'b11, 2'b00, 1'b0, "reject");
        check("rej/count", 96'(count), 96'(7));
        cycle(2'b00, 2'b11, 1'b0, "deq2");
        check("c5/count", 96'(count), 96'(5));
        check("c5/in_ready", 96'(in_ready), 96'(1));

        // Reach full, then dequeue while enqueue is refused.
        cycle(2'b01, 2'b00, 1'b0, "fill6");
        cycle(2'b11, 2'b00, 1'b0, "fill8");
        check("full/count", 96'(count), 96'(8));
        check("full/in_ready", 96'(in_ready), 96'(0));
        cycle(2'b11, 2'b01, 1'b0, "full_deq");
        cycle(2'b00, 2'b11, 1'b0, "drain2");
        cycle(2'b10, 2'b00, 1'b0, "enq_gap");
        check("enq_gap/count", 96'(count), 96'(5));

        // Flush beats same-cycle enqueue and dequeue.
        cycle(2'b11, 2'b11, 1'b1, "flush");
        check("flush/count", 96'(count), 96'(0));
        check("flush/valid", 96'({dispatch_packet[1].valid, dispatch_packet[0].valid}), 96'(0));
        cycle(2'b00, 2'b11, 1'b0, "empty_deq");

        // Streaming across the 7->0 wrap, then random traffic; order must survive.
        sent.delete();
        got.delete();
        for (int c = 0; c < 20; c++) begin
            cycle(2'b11, 2'b11, 1'b0, "stream");
        end
        for (int c = 0; c < 60; c++) begin
            cycle(2'($urandom), 2'($urandom), 1'b0, "rand");
        end
        for (int c = 0; c < 10 && model_q.size() > 0; c++) begin
            cycle(2'b00, 2'b11, 1'b0, "drain");
        end
        check("order/size", 96'(got.size()), 96'(sent.size()));
        for (int k = 0; k < got.size() && k < sent.size(); k++) begin
            check($sformatf("order/%0d", k), 96'(got[k]), 96'(sent[k]));
        end

        // Random traffic with occasional flushes.
        for (int c = 0; c < 80; c++) begin
            cycle(2'($urandom), 2'($urandom), ($urandom_range(0, 11) == 0), "rand_flush");
        end

        // Asynchronous reset mid-stream, observed before any clock edge.
        cycle(2'b11, 2'b00, 1'b0, "pre_rst1");
        cycle(2'b11, 2'b00, 1'b0, "pre_rst2");
        in_valid = '0;
        #2;
        reset = 1'b0;
        #1;
        model_q.delete();
        check("async_rst/count", 96'(count), 96'(0));
        check("async_rst/in_ready", 96'(in_ready), 96'(1));
        check("async_rst/valid", 96'({dispatch_packet[1].valid, dispatch_packet[0].valid}), 96'(0));
        @(negedge clock);
        reset = 1'b1;
        cycle(2'b11, 2'b00, 1'b0, "post_rst");
        check("post_rst/count", 96'(count), 96'(2));
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
